// File: rtl/hex_display_ctrl_if.sv
// Requester/display bundle for hex_display_ctrl: two valid/ready word ports,
// the hold control and the committed segment outputs.
interface hex_display_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      a_valid;
  logic [4*NUM_DIGITS-1:0]   a_data;
  logic                      a_ready;
  logic                      b_valid;
  logic [4*NUM_DIGITS-1:0]   b_data;
  logic                      b_ready;
  logic                      hold;
  logic [7*NUM_DIGITS-1:0]   seg_out;
  logic                      owner;
  logic                      busy;

  modport master (
    output a_valid, a_data, b_valid, b_data, hold,
    input  a_ready, b_ready, seg_out, owner, busy
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data, hold,
    output a_ready, b_ready, seg_out, owner, busy
  );
endinterface

// File: rtl/hex_display_ctrl.sv
// Round-robin arbiter feeding a single hex-to-seven decoder that walks the
// digits one per cycle and commits the full segment bank in one edge.
module hex_display_ctrl #(
  parameter int NUM_DIGITS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  hex_display_ctrl_if.slave bus
);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SI_W  = IDX_W + 3;
  localparam int WW    = 4 * NUM_DIGITS;
  localparam int SW    = 7 * NUM_DIGITS;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_DECODE = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              prio_a_q, prio_a_d;
  logic [WW-1:0]     word_q, word_d;
  logic              pend_owner_q, pend_owner_d;
  logic [SW-1:0]     shadow_q, shadow_d;
  logic [SW-1:0]     seg_q, seg_d;
  logic              owner_q, owner_d;

  logic              a_ready_s, b_ready_s;
  logic              grant_a_s, grant_b_s;
  logic [3:0]        nibble_s;
  logic [6:0]        dec_s;
  logic [SI_W-1:0]   slot_base_s;
  logic              last_s;

  // Active-low g..a pattern for one hex nibble
  function automatic logic [6:0] hex_to_seven(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0:    p = 7'b1000000;
      4'h1:    p = 7'b1111001;
      4'h2:    p = 7'b0100100;
      4'h3:    p = 7'b0110000;
      4'h4:    p = 7'b0011001;
      4'h5:    p = 7'b0010010;
      4'h6:    p = 7'b0000010;
      4'h7:    p = 7'b1111000;
      4'h8:    p = 7'b0000000;
      4'h9:    p = 7'b0010000;
      4'hA:    p = 7'b0001000;
      4'hB:    p = 7'b0000011;
      4'hC:    p = 7'b1000110;
      4'hD:    p = 7'b0100001;
      4'hE:    p = 7'b0000110;
      4'hF:    p = 7'b0001110;
      default: p = 7'b1111111;
    endcase
    return p;
  endfunction

  // Arbitration, decode sequencing and commit next-state logic
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    prio_a_d     = prio_a_q;
    word_d       = word_q;
    pend_owner_d = pend_owner_q;
    shadow_d     = shadow_q;
    seg_d        = seg_q;
    owner_d      = owner_q;
    a_ready_s    = 1'b0;
    b_ready_s    = 1'b0;
    grant_a_s    = 1'b0;
    grant_b_s    = 1'b0;
    nibble_s     = word_q[{idx_q, 2'b00} +: 4];
    dec_s        = hex_to_seven(nibble_s);
    slot_base_s  = SI_W'(idx_q) * SI_W'(7);
    last_s       = (idx_q == IDX_W'(NUM_DIGITS - 1));

    case (state_q)
      ST_IDLE: begin
        if (!bus.hold) begin
          a_ready_s = !bus.b_valid | prio_a_q;
          b_ready_s = !bus.a_valid | !prio_a_q;
        end else begin
          a_ready_s = 1'b0;
          b_ready_s = 1'b0;
        end
        grant_a_s = bus.a_valid & a_ready_s;
        grant_b_s = bus.b_valid & b_ready_s;
        if (grant_a_s || grant_b_s) begin
          state_d      = ST_DECODE;
          idx_d        = '0;
          word_d       = grant_a_s ? bus.a_data : bus.b_data;
          pend_owner_d = grant_b_s;
          // Favour whichever requester was not just served
          prio_a_d     = grant_b_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DECODE: begin
        shadow_d[slot_base_s +: 7] = dec_s;
        idx_d = idx_q + IDX_W'(1);
        if (last_s) begin
          // The final pattern bypasses the shadow so all digits land together
          state_d = ST_IDLE;
          idx_d   = '0;
          seg_d   = shadow_d;
          owner_d = pend_owner_q;
        end else begin
          state_d = ST_DECODE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      prio_a_q     <= 1'b1;
      word_q       <= '0;
      pend_owner_q <= 1'b0;
      shadow_q     <= '0;
      seg_q        <= {SW{1'b1}};
      owner_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      prio_a_q     <= prio_a_d;
      word_q       <= word_d;
      pend_owner_q <= pend_owner_d;
      shadow_q     <= shadow_d;
      seg_q        <= seg_d;
      owner_q      <= owner_d;
    end
  end

  assign bus.a_ready = a_ready_s;
  assign bus.b_ready = b_ready_s;
  assign bus.seg_out = seg_q;
  assign bus.owner   = owner_q;
  assign bus.busy    = (state_q == ST_DECODE);
endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl with NUM_DIGITS = 4; expected segment
// patterns are written out by hand from the decoder table.
module tb_hex_display_ctrl;
  localparam int ND = 4;
  localparam logic [6:0] P0 = 7'b1000000;
  localparam logic [6:0] P1 = 7'b1111001;
  localparam logic [6:0] P2 = 7'b0100100;
  localparam logic [6:0] P3 = 7'b0110000;
  localparam logic [6:0] P4 = 7'b0011001;
  localparam logic [6:0] PA = 7'b0001000;
  localparam logic [6:0] PB = 7'b0000011;
  localparam logic [6:0] PF = 7'b0001110;
  localparam logic [27:0] BLANK = 28'hFFFFFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  hex_display_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  hex_display_ctrl #(.NUM_DIGITS(ND)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #3;
    rst_n = 1'b0;
    #2;
    n_checks++; if (bus.seg_out !== BLANK) begin n_fail++; $display("FAIL rst_seg: got %h want %h", bus.seg_out, BLANK); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    step();
    step();
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.seg_out !== BLANK) begin n_fail++; $display("FAIL post_rst_seg: got %h want %h", bus.seg_out, BLANK); end
    n_checks++; if (bus.owner !== 1'b0) begin n_fail++; $display("FAIL post_rst_owner: got %b want 0", bus.owner); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_a_ready: got %b want 1", bus.a_ready); end
    n_checks++; if (bus.b_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_b_ready: got %b want 1", bus.b_ready); end
  endtask

  task automatic test_single_a();
    bus.a_data  = 16'h1234;
    bus.a_valid = 1'b1;
    #1;
    n_checks++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL single_accept: a_ready got %b want 1", bus.a_ready); end
    step();
    bus.a_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy T+%0d: got %b want 1", k, bus.busy); end
      n_checks++; if (bus.seg_out !== BLANK) begin n_fail++; $display("FAIL single_blank T+%0d: got %h want %h", k, bus.seg_out, BLANK); end
      n_checks++; if (bus.a_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_low T+%0d: got %b want 0", k, bus.a_ready); end
      step();
    end
    #1;
    n_checks++; if (bus.seg_out !== {P1, P2, P3, P4}) begin n_fail++; $display("FAIL single_seg: got %h want %h", bus.seg_out, {P1, P2, P3, P4}); end
    n_checks++; if (bus.owner !== 1'b0) begin n_fail++; $display("FAIL single_owner: got %b want 0", bus.owner); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b want 0", bus.busy); end
    n_checks++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_back: got %b want 1", bus.a_ready); end
  endtask

  task automatic test_tie();
    do_reset();
    bus.a_data  = 16'hAAAA;
    bus.b_data  = 16'hBBBB;
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    #1;
    n_checks++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL tie_a_ready: got %b want 1", bus.a_ready); end
    n_checks++; if (bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL tie_b_ready: got %b want 0", bus.b_ready); end
    step();
    bus.a_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      n_checks++; if (bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL tie_b_wait T+%0d: got %b want 0", k, bus.b_ready); end
      step();
    end
    #1;
    n_checks++; if (bus.seg_out !== {4{PA}}) begin n_fail++; $display("FAIL tie_seg_a: got %h want %h", bus.seg_out, {4{PA}}); end
    n_checks++; if (bus.owner !== 1'b0) begin n_fail++; $display("FAIL tie_owner_a: got %b want 0", bus.owner); end
    n_checks++; if (bus.b_ready !== 1'b1) begin n_fail++; $display("FAIL tie_b_ready_T5: got %b want 1", bus.b_ready); end
    step();
    bus.b_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    #1;
    n_checks++; if (bus.seg_out !== {4{PB}}) begin n_fail++; $display("FAIL tie_seg_b: got %h want %h", bus.seg_out, {4{PB}}); end
    n_checks++; if (bus.owner !== 1'b1) begin n_fail++; $display("FAIL tie_owner_b: got %b want 1", bus.owner); end
  endtask

  task automatic test_fairness();
    logic exp_b;
    int   next_grant;
    int   n_grants;
    exp_b      = 1'b0;
    next_grant = 0;
    n_grants   = 0;
    bus.a_data  = 16'h1111;
    bus.b_data  = 16'h2222;
    bus.a_valid = 1'b1;
    bus.b_valid = 1'b1;
    for (int c = 0; c < 30; c++) begin
      #1;
      n_checks++; if (bus.a_ready && bus.b_ready) begin n_fail++; $display("FAIL fair_exclusive c%0d: both readies high", c); end
      if (bus.a_ready || bus.b_ready) begin
        n_checks++;
        if (c != next_grant || bus.b_ready !== exp_b) begin
          n_fail++;
          $display("FAIL fair_grant c%0d: got b=%b want b=%b at cycle %0d", c, bus.b_ready, exp_b, next_grant);
        end
        exp_b      = ~exp_b;
        next_grant = c + 5;
        n_grants++;
      end
      step();
    end
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    #1;
    n_checks++; if (n_grants != 6) begin n_fail++; $display("FAIL fair_count: got %0d want 6", n_grants); end
    n_checks++; if (bus.seg_out !== {4{P2}}) begin n_fail++; $display("FAIL fair_seg: got %h want %h", bus.seg_out, {4{P2}}); end
    n_checks++; if (bus.owner !== 1'b1) begin n_fail++; $display("FAIL fair_owner: got %b want 1", bus.owner); end
  endtask

  task automatic test_hold();
    bus.hold    = 1'b1;
    bus.a_data  = 16'hFFFF;
    bus.a_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      n_checks++; if (bus.a_ready !== 1'b0) begin n_fail++; $display("FAIL hold_a_ready c%0d: got %b want 0", k, bus.a_ready); end
      n_checks++; if (bus.b_ready !== 1'b0) begin n_fail++; $display("FAIL hold_b_ready c%0d: got %b want 0", k, bus.b_ready); end
      n_checks++; if (bus.seg_out !== {4{P2}}) begin n_fail++; $display("FAIL hold_seg c%0d: got %h want %h", k, bus.seg_out, {4{P2}}); end
      step();
    end
    bus.hold = 1'b0;
    #1;
    n_checks++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL hold_release: got %b want 1", bus.a_ready); end
    step();
    bus.a_valid = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy T+1: got %b want 1", bus.busy); end
    step();
    bus.hold = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      #1;
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL hold_mid_busy T+%0d: got %b want 1", k, bus.busy); end
      step();
    end
    #1;
    n_checks++; if (bus.seg_out !== {4{PF}}) begin n_fail++; $display("FAIL hold_seg_f: got %h want %h", bus.seg_out, {4{PF}}); end
    n_checks++; if (bus.owner !== 1'b0) begin n_fail++; $display("FAIL hold_owner: got %b want 0", bus.owner); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL hold_done: got %b want 0", bus.busy); end
    n_checks++; if (bus.a_ready !== 1'b0) begin n_fail++; $display("FAIL hold_blocks: got %b want 0", bus.a_ready); end
    bus.hold = 1'b0;
  endtask

  task automatic test_reset_mid_decode();
    bus.a_data  = 16'h5678;
    bus.a_valid = 1'b1;
    #1;
    step();
    bus.a_valid = 1'b0;
    step();
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.seg_out !== BLANK) begin n_fail++; $display("FAIL mid_rst_seg: got %h want %h", bus.seg_out, BLANK); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", bus.busy); end
    step();
    rst_n = 1'b1;
    #1;
    bus.a_data  = 16'h0000;
    bus.a_valid = 1'b1;
    #1;
    n_checks++; if (bus.a_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_accept: got %b want 1", bus.a_ready); end
    step();
    bus.a_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      n_checks++; if (bus.seg_out !== BLANK) begin n_fail++; $display("FAIL mid_rst_no_trace T+%0d: got %h want %h", k, bus.seg_out, BLANK); end
      step();
    end
    #1;
    n_checks++; if (bus.seg_out !== {4{P0}}) begin n_fail++; $display("FAIL mid_rst_seg0: got %h want %h", bus.seg_out, {4{P0}}); end
    n_checks++; if (bus.owner !== 1'b0) begin n_fail++; $display("FAIL mid_rst_owner: got %b want 0", bus.owner); end
  endtask

  initial begin
    bus.a_valid = 1'b0;
    bus.a_data  = '0;
    bus.b_valid = 1'b0;
    bus.b_data  = '0;
    bus.hold    = 1'b0;
    test_reset();
    test_single_a();
    test_tie();
    test_fairness();
    test_hold();
    test_reset_mid_decode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
